mag_window_stats: RTL and testbench
===================================

// Module: mag_window_stats
// PURPOSE
//  Downstream consumer of the magnitude stage's 8-bit sqrt(x^2+y^2) result.
//  Gathers magnitude samples into fixed windows of 2^WIN_LOG2 samples. Per window it reports
//  the average, maximum and minimum over a valid/ready handshake.
//  It also drives a threshold alarm with hysteresis, updated at each window close.
// PARAMETERS
//  DATA_W    8  width of magnitude samples and of every statistic output
//  WIN_LOG2  3  log2 of window length (default 8 samples); legal range 1..6
//  HYST      4  alarm release hysteresis, in magnitude LSBs
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset; asynchronous, active-low
//  ena        in   1       global enable; low = all state frozen, outputs held
//  clear      in   1       synchronous window abort; discards partial window
//  mag_in     in   DATA_W  magnitude sample from upstream sqrt stage
//  mag_valid  in   1       mag_in valid this cycle
//  mag_ready  out  1       block can accept a sample (high only in ACCUM)
//  thresh     in   DATA_W  alarm set level, sampled at window close
//  out_valid  out  1       statistics valid; held until out_ready
//  out_ready  in   1       downstream accepts statistics
//  out_avg    out  DATA_W  window sum >> WIN_LOG2 (truncating)
//  out_max    out  DATA_W  largest sample in window
//  out_min    out  DATA_W  smallest sample in window
//  alarm      out  1       threshold alarm, hysteretic
// BEHAVIOUR
//  Reset: state=ACCUM, sum=0, cnt=0, run_max=0, run_min=all-ones, out_valid=0,
//   out_avg=out_max=out_min=0, alarm=0, mag_ready=1.
//  ena=0: no register updates; mag_ready forced 0; out_valid holds its value.
//  FSM, 2 states:
//   ACCUM: sample accepted when mag_valid&mag_ready. sum+=mag_in (width DATA_W+WIN_LOG2, no
//    overflow possible). run_max/run_min update. cnt increments (WIN_LOG2 bits).
//    Accept with cnt==2^WIN_LOG2-1 closes the window. It goes to REPORT the same edge.
//    Outputs load that edge from statistics that include the closing sample.
//    out_valid=1 the next cycle: one cycle latency from last sample to out_valid.
//    On close, sum/cnt/run_max/run_min return to reset values.
//   REPORT: mag_ready=0 (upstream back-pressured). out_* stable while out_valid.
//    out_valid&out_ready -> out_valid=0, state=ACCUM; mag_ready=1 the next cycle.
//  Alarm, evaluated on the window-close edge with new avg:
//   avg>=thresh -> alarm=1. avg<thresh-HYST -> alarm=0, else hold.
//   thresh-HYST saturates at 0; at 0 the alarm never releases.
//  clear (ena=1): sum/cnt/run_max/run_min to reset values. A coincident sample is dropped.
//   In REPORT, clear also drops out_valid and returns to ACCUM. alarm and out_* data keep their values.
//  clear overrides out_ready and window close on the same edge.
//  Reset mid-window: partial window lost; no statistics emitted for it.
//  Equal max/min (constant input) is legal; min=max=sample value.
// STRUCTURE
//  Shared package mag_pkg: DATA_W default, state typedef {ACCUM, REPORT}, and the
//   MAG_MIN_INIT (all-ones) constant, shared with the sqrt stage.
//  Single module. The accumulator/extrema datapath may be split into sub-module
//   mag_win_accum (sum, cnt, run_max, run_min, close strobe). The FSM, handshake and alarm stay at top.
// TESTING
//  8 samples of 5, out_ready=1 -> one pulse out_valid, avg=5 max=5 min=5, 1 cycle after 8th.
//  Samples 0..7 -> avg=3 (28>>3), max=7, min=0.
//  out_ready=0 for 10 cycles after close -> out_valid/out_* stable, mag_ready=0; no samples lost.
//  thresh=10, HYST=4: window avgs 12,8,5 -> alarm 1,1,0.
//  clear after 5 samples, then 8 samples of 200 -> avg=200, max=200, min=200.
//  rst_n low mid-window (3 samples), then ena toggled low between samples -> all outputs at reset values.
//   The next full window then yields correct statistics with no extra or missed out_valid.

Source files
------------

// File: rtl/mag_pkg.sv
// mag_pkg: definitions shared between the magnitude (sqrt) stage and the
// window statistics block.
//   MAG_DATA_W   default magnitude sample width
//   MAG_MIN_INIT running-minimum start value (all ones)
//   mag_state_t  window statistics FSM states
package mag_pkg;

    localparam int MAG_DATA_W = 8;

    localparam logic [MAG_DATA_W-1:0] MAG_MIN_INIT = '1;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } mag_state_t;

endpackage

// File: rtl/mag_win_accum.sv
// mag_win_accum: window accumulator and extrema tracker.
// It keeps the running sum, sample count, maximum and minimum. It presents
// those statistics with the current sample already folded in, so that the
// top level can latch them on the edge that accepts the closing sample.
//   clk, rst_n   clock, async active-low reset
//   i_ena        global enable; low freezes all registers
//   i_clear      synchronous abort of the partial window
//   i_accept     a sample is taken this cycle
//   i_sample     sample value
//   o_close      this accept completes the window
//   o_avg        (sum + sample) >> WIN_LOG2
//   o_max/o_min  extrema including the current sample
module mag_win_accum
    import mag_pkg::*;
#(
    parameter int DATA_W   = MAG_DATA_W,
    parameter int WIN_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ena,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_close,
    output logic [DATA_W-1:0] o_avg,
    output logic [DATA_W-1:0] o_max,
    output logic [DATA_W-1:0] o_min
);

    localparam int SUM_W = DATA_W + WIN_LOG2;
    localparam logic [DATA_W-1:0] MIN_INIT =
        (DATA_W == MAG_DATA_W) ? DATA_W'(MAG_MIN_INIT) : {DATA_W{1'b1}};

    logic [SUM_W-1:0]    r_sum;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_min;

    logic [SUM_W-1:0]    w_sum_nxt;
    logic [DATA_W-1:0]   w_max_nxt;
    logic [DATA_W-1:0]   w_min_nxt;
    logic                w_take;

    // A sample that coincides with clear is dropped.
    assign w_take    = i_ena & i_accept & ~i_clear;
    assign w_sum_nxt = r_sum + SUM_W'(i_sample);
    assign w_max_nxt = (i_sample > r_max) ? i_sample : r_max;
    assign w_min_nxt = (i_sample < r_min) ? i_sample : r_min;

    assign o_close = w_take & (r_cnt == '1);
    assign o_avg   = w_sum_nxt[SUM_W-1:WIN_LOG2];
    assign o_max   = w_max_nxt;
    assign o_min   = w_min_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_max <= '0;
            r_min <= MIN_INIT;
        end else if (i_ena) begin
            if (i_clear || o_close) begin
                r_sum <= '0;
                r_cnt <= '0;
                r_max <= '0;
                r_min <= MIN_INIT;
            end else if (i_accept) begin
                r_sum <= w_sum_nxt;
                r_cnt <= r_cnt + WIN_LOG2'(1);
                r_max <= w_max_nxt;
                r_min <= w_min_nxt;
            end
        end
    end

endmodule

// File: rtl/mag_window_stats.sv
// mag_window_stats: per-window average/max/min of magnitude samples, with a
// valid/ready report and a hysteretic threshold alarm.
//   clk, rst_n            clock, async active-low reset
//   ena                   global enable (low freezes everything, mag_ready=0)
//   clear                 synchronous abort of the partial window / pending report
//   mag_in, mag_valid     sample input; mag_ready high only in ACCUM
//   thresh                alarm set level, sampled at window close
//   out_valid, out_ready  statistics handshake
//   out_avg/max/min       window statistics
//   alarm                 set when avg>=thresh, released when avg<thresh-HYST
//
// state  | meaning
// ACCUM  | taking samples; a window close moves to REPORT
// REPORT | statistics held with out_valid=1, upstream back-pressured
module mag_window_stats
    import mag_pkg::*;
#(
    parameter int DATA_W   = MAG_DATA_W,
    parameter int WIN_LOG2 = 3,
    parameter int HYST     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic [DATA_W-1:0] mag_in,
    input  logic              mag_valid,
    output logic              mag_ready,
    input  logic [DATA_W-1:0] thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic              alarm
);

    mag_state_t        r_state;
    mag_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_avg;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic              r_alarm;

    logic              w_accept;
    logic              w_close;
    logic [DATA_W-1:0] w_avg;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_rel_lvl;

    assign mag_ready = ena & (r_state == ACCUM);
    assign out_valid = (r_state == REPORT);
    assign w_accept  = mag_valid & mag_ready;

    assign out_avg = r_avg;
    assign out_max = r_max;
    assign out_min = r_min;
    assign alarm   = r_alarm;

    mag_win_accum #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ena    (ena),
        .i_clear  (clear),
        .i_accept (w_accept),
        .i_sample (mag_in),
        .o_close  (w_close),
        .o_avg    (w_avg),
        .o_max    (w_max),
        .o_min    (w_min)
    );

    // Release level saturates at zero; a zero level can never be undercut.
    assign w_rel_lvl = (thresh > DATA_W'(HYST)) ? (thresh - DATA_W'(HYST)) : '0;

    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            case (r_state)
                ACCUM:  if (w_close) w_state_nxt = REPORT;
                REPORT: if (clear || out_ready) w_state_nxt = ACCUM;
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_close already carries ena and the clear override.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg   <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_alarm <= 1'b0;
        end else if (w_close) begin
            r_avg <= w_avg;
            r_max <= w_max;
            r_min <= w_min;
            if (w_avg >= thresh) begin
                r_alarm <= 1'b1;
            end else if (w_avg < w_rel_lvl) begin
                r_alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mag_window_stats.sv
// tb_mag_window_stats: scoreboard bench for mag_window_stats (default params).
module tb_mag_window_stats;

    typedef struct {
        logic [7:0] avg;
        logic [7:0] max;
        logic [7:0] min;
        logic       alarm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] mag_in = '0;
    logic       mag_valid = 1'b0;
    logic       mag_ready;
    logic [7:0] thresh = 8'd255;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_avg;
    logic [7:0] out_max;
    logic [7:0] out_min;
    logic       alarm;

    int   total = 0;
    int   bad = 0;
    int   n_push = 0;
    int   n_pop = 0;
    bit   m_alarm = 1'b0;
    exp_t sb[$];
    exp_t e;

    mag_window_stats dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (clear),
        .mag_in    (mag_in),
        .mag_valid (mag_valid),
        .mag_ready (mag_ready),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_avg   (out_avg),
        .out_max   (out_max),
        .out_min   (out_min),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    // Each accepted report is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_report got avg=%0d max=%0d min=%0d want no report",
                         out_avg, out_max, out_min);
            end else begin
                e = sb.pop_front();
                n_pop++;
                if ({out_avg, out_max, out_min, alarm} !== {e.avg, e.max, e.min, e.alarm}) begin
                    bad++;
                    $display("FAIL window_stats got avg=%0d max=%0d min=%0d alarm=%0b want avg=%0d max=%0d min=%0d alarm=%0b",
                             out_avg, out_max, out_min, alarm, e.avg, e.max, e.min, e.alarm);
                end
            end
        end
    end

    function automatic exp_t model_window(input int v[8]);
        exp_t r;
        int   s, mx, mn, lvl;
        s = 0; mx = 0; mn = 255;
        for (int i = 0; i < 8; i++) begin
            s += v[i];
            if (v[i] > mx) mx = v[i];
            if (v[i] < mn) mn = v[i];
        end
        r.avg = 8'(s >> 3);
        r.max = 8'(mx);
        r.min = 8'(mn);
        lvl = (int'(thresh) > 4) ? int'(thresh) - 4 : 0;
        if (int'(r.avg) >= int'(thresh)) m_alarm = 1'b1;
        else if (int'(r.avg) < lvl) m_alarm = 1'b0;
        r.alarm = m_alarm;
        return r;
    endfunction

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        mag_in = v;
        mag_valid = 1'b1;
        @(negedge clk);
        while (!mag_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL send_timeout mag_ready=%0b want 1", mag_ready);
        end
        @(posedge clk);
        #1 mag_valid = 1'b0;
    endtask

    task automatic send_window(input int v[8], input bit push);
        exp_t x;
        x = model_window(v);
        if (push) begin
            sb.push_back(x);
            n_push++;
        end
        for (int i = 0; i < 8; i++) send(8'(v[i]));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL idle_timeout out_valid=%0b want 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic const_window(input int c, output int w[8]);
        for (int i = 0; i < 8; i++) w[i] = c;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({out_valid, mag_ready, out_avg, out_max, out_min, alarm} !== {1'b0, 1'b1, 24'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got v=%0b r=%0b avg=%0d max=%0d min=%0d al=%0b want v=0 r=1 0 0 0 al=0",
                     out_valid, mag_ready, out_avg, out_max, out_min, alarm);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int w[8];
        const_window(5, w);
        out_ready = 1'b1;
        send_window(w, 1'b1);
        total++;
        if (out_valid !== 1'b1 || mag_ready !== 1'b0) begin
            bad++;
            $display("FAIL close_latency got out_valid=%0b mag_ready=%0b want 1 0", out_valid, mag_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || mag_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_pulse got out_valid=%0b mag_ready=%0b want 0 1", out_valid, mag_ready);
        end
    endtask

    task automatic test_ramp();
        int w[8];
        for (int i = 0; i < 8; i++) w[i] = i;
        send_window(w, 1'b1);
        wait_idle();
    endtask

    task automatic test_backpressure();
        int w[8];
        for (int i = 0; i < 8; i++) w[i] = 10 + i;
        out_ready = 1'b0;
        send_window(w, 1'b1);
        mag_in = 8'd99;
        mag_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_avg !== 8'd13 || out_max !== 8'd17 ||
                out_min !== 8'd10 || mag_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got v=%0b avg=%0d max=%0d min=%0d r=%0b want v=1 avg=13 max=17 min=10 r=0",
                         c, out_valid, out_avg, out_max, out_min, mag_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        w[0] = 99;
        for (int i = 1; i < 8; i++) w[i] = i;
        send_window(w, 1'b1);
        wait_idle();
    endtask

    task automatic test_alarm();
        int w[8];
        int avgs[3];
        bit want[3];
        avgs = '{12, 8, 5};
        want = '{1'b1, 1'b1, 1'b0};
        thresh = 8'd10;
        for (int k = 0; k < 3; k++) begin
            const_window(avgs[k], w);
            send_window(w, 1'b1);
            wait_idle();
            total++;
            if (alarm !== want[k]) begin
                bad++;
                $display("FAIL alarm_hyst avg=%0d got %0b want %0b", avgs[k], alarm, want[k]);
            end
        end
    endtask

    task automatic test_clear();
        int w[8];
        for (int i = 0; i < 5; i++) send(8'd50);
        mag_in = 8'd77;
        mag_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        mag_valid = 1'b0;
        const_window(200, w);
        send_window(w, 1'b1);
        wait_idle();
        // clear while a report is pending
        out_ready = 1'b0;
        const_window(3, w);
        send_window(w, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        total++;
        if (out_valid !== 1'b0 || mag_ready !== 1'b1 || out_avg !== 8'd3 || alarm !== 1'b0) begin
            bad++;
            $display("FAIL clear_report got v=%0b r=%0b avg=%0d al=%0b want v=0 r=1 avg=3 al=0",
                     out_valid, mag_ready, out_avg, alarm);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int   w[8];
        exp_t x;
        thresh = 8'd10;
        const_window(12, w);
        send_window(w, 1'b1);
        wait_idle();
        for (int i = 0; i < 3; i++) send(8'd40);
        rst_n = 1'b0;
        m_alarm = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, mag_ready, out_avg, out_max, out_min, alarm} !== {1'b0, 1'b1, 24'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got v=%0b r=%0b avg=%0d max=%0d min=%0d al=%0b want v=0 r=1 0 0 0 al=0",
                     out_valid, mag_ready, out_avg, out_max, out_min, alarm);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = 30 + i;
        x = model_window(w);
        sb.push_back(x);
        n_push++;
        send(8'd30);
        ena = 1'b0;
        mag_in = 8'd250;
        mag_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (mag_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL ena_freeze got mag_ready=%0b out_valid=%0b want 0 0", mag_ready, out_valid);
            end
        end
        @(posedge clk);
        #1 ena = 1'b1;
        mag_valid = 1'b0;
        for (int i = 1; i < 8; i++) send(8'(30 + i));
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_backpressure();
        test_alarm();
        test_clear();
        test_reset_mid();
        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0 || n_pop != n_push) begin
            bad++;
            $display("FAIL report_count got pops=%0d left=%0d want pops=%0d left=0",
                     n_pop, sb.size(), n_push);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
